// File: rtl/bank_prefetcher_if.sv
// bank_prefetcher_if: CPU command/response handshake bundle for bank_prefetcher
interface bank_prefetcher_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/bank_prefetcher.sv
// bank_prefetcher: streams words from four interleaved banks into a FIFO for CPU POPs; STATUS op gated by BANK_PREFETCHER_STATUS_EN
module bank_prefetcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              reset,
  bank_prefetcher_if.slave  bus,
  output logic [ADDR_W-1:0] port0_addr,
  output logic [ADDR_W-1:0] port1_addr,
  output logic [ADDR_W-1:0] port2_addr,
  output logic [ADDR_W-1:0] port3_addr,
  output logic              port0_ren,
  output logic              port1_ren,
  output logic              port2_ren,
  output logic              port3_ren,
  input  logic [31:0]       port0_din,
  input  logic [31:0]       port1_din,
  input  logic [31:0]       port2_din,
  input  logic [31:0]       port3_din
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t            state;
  logic [15:0]       idx, rem;
  logic              inflight;
  logic [1:0]        ibank;
  logic [31:0]       fifo [FIFO_DEPTH];
  logic [PW-1:0]     head, tail;
  logic [3:0]        level;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [31:0]       din [4];
  logic [2:0]        op;
  logic              issue, pop_stall, accept, start_acc, pop_acc, bypass, pop_fifo, push;
  logic [3:0]        ren;
  logic [ADDR_W-1:0] row;
  logic [31:0]       pop_data, status, rsp_val;
  logic              unused;
  assign din[0] = port0_din;
  assign din[1] = port1_din;
  assign din[2] = port2_din;
  assign din[3] = port3_din;
  assign op = bus.cmd_payload_function_id[2:0];
  assign unused = ^{bus.cmd_payload_function_id[9:3], bus.cmd_payload_inputs_0[31:16], bus.cmd_payload_inputs_1[31:16]};
  assign issue = state == STREAM && level + 4'(inflight) < 4'(FIFO_DEPTH);
  assign pop_stall = op == 3'd1 && level == 4'd0 && !inflight && rem != 16'd0;
  assign bus.cmd_ready = !rsp_valid && !pop_stall;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign start_acc = accept && op == 3'd0;
  assign pop_acc = accept && op == 3'd1;
  assign bypass = pop_acc && level == 4'd0 && inflight;
  assign pop_fifo = pop_acc && level != 4'd0;
  assign push = inflight && !bypass && !start_acc;
  assign row = ADDR_W'(idx[15:2]);
  assign ren = issue ? 4'b0001 << idx[1:0] : 4'b0000;
  assign {port3_ren, port2_ren, port1_ren, port0_ren} = ren;
  assign port0_addr = ren[0] ? row : '0;
  assign port1_addr = ren[1] ? row : '0;
  assign port2_addr = ren[2] ? row : '0;
  assign port3_addr = ren[3] ? row : '0;
  assign pop_data = level != 4'd0 ? fifo[head] : inflight ? din[ibank] : '0;
`ifdef BANK_PREFETCHER_STATUS_EN
  logic [15:0] rem_total;
  assign rem_total = rem + 16'(inflight) + 16'(level);
  assign status = {rem_total, 12'b0, level};
`else
  assign status = '0;
`endif
  assign rsp_val = op == 3'd1 ? pop_data : op == 3'd2 ? status : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_payload_outputs_0 = rsp_data;
  always_ff @(posedge clk)
    if (push) fifo[tail] <= din[ibank];
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      rem <= '0;
      inflight <= 1'b0;
      ibank <= '0;
      head <= '0;
      tail <= '0;
      level <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      inflight <= issue;
      ibank <= idx[1:0];
      if (issue) begin
        idx <= idx + 16'd1;
        rem <= rem - 16'd1;
        if (rem == 16'd1) state <= IDLE;
      end
      if (push) tail <= tail + 1'b1;
      if (pop_fifo) head <= head + 1'b1;
      level <= level + 4'(push) - 4'(pop_fifo);
      if (start_acc) begin
        idx <= bus.cmd_payload_inputs_0[15:0];
        rem <= bus.cmd_payload_inputs_1[15:0];
        state <= bus.cmd_payload_inputs_1[15:0] != 16'd0 ? STREAM : IDLE;
        inflight <= 1'b0;
        head <= '0;
        tail <= '0;
        level <= '0;
      end
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_data <= rsp_val;
      end else if (bus.rsp_ready) rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_bank_prefetcher.sv
// tb_bank_prefetcher: table, directed and randomized checks of bank_prefetcher against a word-queue model
module tb_bank_prefetcher;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  bank_prefetcher_if bus();
  logic [13:0] a0, a1, a2, a3;
  logic r0, r1, r2, r3;
  logic [31:0] d0, d1, d2, d3;
  bank_prefetcher #(.FIFO_DEPTH(4), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .port0_addr(a0), .port1_addr(a1), .port2_addr(a2), .port3_addr(a3),
    .port0_ren(r0), .port1_ren(r1), .port2_ren(r2), .port3_ren(r3),
    .port0_din(d0), .port1_din(d1), .port2_din(d2), .port3_din(d3)
  );
  typedef struct {int cyc; int bank; logic [13:0] row;} rd_t;
  typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; bit chk_d; bit nostall;} vec_t;
  rd_t log_q[$];
  logic [31:0] q[$];
  logic [15:0] salt = 16'h0;
  int cyc = 0;
  int onehot_err = 0;
  int total = 0;
  int passed = 0;
  function automatic logic [31:0] word(input logic [15:0] w);
    return {salt, w};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    d0 <= r0 ? word({a0, 2'd0}) : $urandom;
    d1 <= r1 ? word({a1, 2'd1}) : $urandom;
    d2 <= r2 ? word({a2, 2'd2}) : $urandom;
    d3 <= r3 ? word({a3, 2'd3}) : $urandom;
    if (r0 | r1 | r2 | r3) begin
      if ($countones({r3, r2, r1, r0}) != 1) onehot_err <= onehot_err + 1;
      log_q.push_back('{cyc, r0 ? 0 : r1 ? 1 : r2 ? 2 : 3, r0 ? a0 : r1 ? a1 : r2 ? a2 : a3});
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else passed++;
  endtask
  task automatic cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                     output logic [31:0] r, output int n, output int acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {7'($urandom), op};
    bus.cmd_payload_inputs_0 = a;
    bus.cmd_payload_inputs_1 = b;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (n >= 200) begin
      total++;
      $display("FAIL cmd_timeout: op %0d got cmd_ready=0 for 200 cycles, expected 1", op);
      bus.cmd_valid = 1'b0;
      r = '0;
      return;
    end
    if (hold > 0) bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rsp_valid_next_cycle", 32'(bus.rsp_valid), 32'd1);
    r = bus.rsp_payload_outputs_0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_hold_data", bus.rsp_payload_outputs_0, r);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] r;
    int n, acc, lim;
    cmd(op, a, b, hold, r, n, acc);
    if (op == 3'd0) begin
      q.delete();
      for (int i = 0; i < int'(b[15:0]); i++) q.push_back(word(16'(a[15:0] + 16'(i))));
    end else if (op == 3'd1) chk("pop_rand", r, q.size() > 0 ? q.pop_front() : 32'd0);
    else if (op == 3'd2) begin
      lim = q.size() < 4 ? q.size() : 4;
`ifdef BANK_PREFETCHER_STATUS_EN
      chk("status_rand", 32'(r[31:16] == 16'(q.size()) && r[15:4] == 12'd0 && int'(r[3:0]) <= lim), 32'd1);
`else
      chk("status_rand", r, 32'd0);
`endif
    end else chk("unknown_op_rand", r, 32'd0);
  endtask
  initial begin
    vec_t tv[18];
    int tacc[18];
    logic [31:0] r;
    int n, acc, acc2, t0, cnt;
    rd_t fr[$];
    tv = '{
      '{3'd0, 32'h0005, 32'd6, 32'd0, 1'b0, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd5, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd6, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd7, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd8, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd9, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd10, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1},
      '{3'd3, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b0},
      '{3'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0},
      '{3'd0, 32'hABCD_FFFE, 32'h0001_0004, 32'd0, 1'b0, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'h0000_FFFE, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'h0000_FFFF, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'h0000_0000, 1'b1, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'h0000_0001, 1'b1, 1'b0},
      '{3'd0, 32'h0020, 32'h0000_0000, 32'd0, 1'b0, 1'b0},
      '{3'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1},
      '{3'd2, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0}
    };
    bus.cmd_valid = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0 = '0;
    bus.cmd_payload_inputs_1 = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_data", bus.rsp_payload_outputs_0, 32'd0);
    chk("reset_ren", 32'({r3, r2, r1, r0}), 32'd0);
    chk("reset_addr", 32'({a0, a1} | {a2, a3}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    foreach (tv[i]) begin
      cmd(tv[i].op, tv[i].a, tv[i].b, 0, r, n, acc);
      tacc[i] = acc;
      if (tv[i].chk_d) chk($sformatf("table_%0d_data", i), r, tv[i].exp);
      if (tv[i].nostall) chk($sformatf("table_%0d_nostall", i), 32'(n), 32'd0);
    end
    fr = log_q.find(x) with (x.cyc > tacc[10] && x.cyc < tacc[15]);
    chk("wrap_reads", 32'(fr.size()), 32'd4);
    if (fr.size() >= 3) begin
      chk("wrap_first_bank_row", {16'(fr[0].bank), 2'b0, fr[0].row}, {16'd2, 16'h3FFF});
      chk("wrap_third_bank_row", {16'(fr[2].bank), 2'b0, fr[2].row}, {16'd0, 16'h0000});
    end
    cmd(3'd0, 32'h0040, 32'd3, 0, r, n, acc);
    t0 = acc + 1;
    cmd(3'd1, 0, 0, 0, r, n, acc2);
    chk("stall_first_word", r, 32'h40);
    chk("stall_rsp_spacing", 32'(acc2 + 1 - t0), 32'd2);
    cmd(3'd1, 0, 0, 0, r, n, acc2);
    chk("stall_second_word", r, 32'h41);
    cmd(3'd1, 0, 0, 0, r, n, acc2);
    chk("stall_third_word", r, 32'h42);
    cmd(3'd0, 32'h0200, 32'd10, 0, r, n, acc);
    repeat (10) @(negedge clk);
    fr = log_q.find(x) with (x.cyc > acc);
    chk("fill_reads_issued", 32'(fr.size()), 32'd4);
    chk("fill_ren_low", 32'({r3, r2, r1, r0}), 32'd0);
    cmd(3'd2, 0, 0, 0, r, n, acc2);
`ifdef BANK_PREFETCHER_STATUS_EN
    chk("fill_status", r, 32'h000A_0004);
`else
    chk("fill_status", r, 32'd0);
`endif
    cmd(3'd0, 32'h0300, 32'd8, 0, r, n, acc);
    cmd(3'd1, 0, 0, 0, r, n, acc);
    chk("restart_pop0", r, 32'h300);
    cmd(3'd1, 0, 0, 0, r, n, acc);
    chk("restart_pop1", r, 32'h301);
    cmd(3'd0, 32'h0100, 32'd1, 0, r, n, acc);
    cmd(3'd1, 0, 0, 3, r, n, acc);
    chk("restart_fresh_word", r, 32'h100);
    cmd(3'd1, 0, 0, 0, r, n, acc);
    chk("restart_drained", r, 32'd0);
    cmd(3'd0, 32'h0500, 32'd20, 0, r, n, acc);
    cmd(3'd1, 0, 0, 0, r, n, acc);
    chk("midreset_pop", r, 32'h500);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_ren", 32'({r3, r2, r1, r0}), 32'd0);
    chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    cmd(3'd1, 0, 0, 0, r, n, acc);
    chk("midreset_pop_zero", r, 32'd0);
    chk("midreset_pop_nostall", 32'(n), 32'd0);
    salt = 16'($urandom);
    q.delete();
    for (int i = 0; i < 400; i++) begin
      int p;
      logic [2:0] op;
      logic [15:0] base, count;
      p = $urandom_range(0, 99);
      op = p < 12 ? 3'd0 : p < 72 ? 3'd1 : p < 82 ? 3'd2 : 3'(3 + $urandom_range(0, 4));
      base = $urandom_range(0, 3) == 0 ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      count = 16'($urandom_range(0, 12));
      run(op, {16'($urandom), base}, {16'($urandom), count}, $urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0);
    end
    cnt = onehot_err;
    chk("ren_onehot", 32'(cnt), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bank_prefetcher.md
BANK_PREFETCHER -- requirements
Module: bank_prefetcher

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, 2..8)
- ADDR_W, 14, per-bank row address width

REQ-002 The block SHALL have these ports (name  direction  width  meaning), one per line:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  CPU command valid
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_payload_function_id  in  10  bits [2:0] select the operation; bits [9:3] ignored
- cmd_payload_inputs_0  in  32  operand 0
- cmd_payload_inputs_1  in  32  operand 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU accepts the response
- rsp_payload_outputs_0  out  32  response data
- portN_addr  out  ADDR_W  bank N row address (N = 0..3)
- portN_ren  out  1  bank N read enable
- portN_din  in  32  bank N read data, valid exactly 1 cycle after ren

Function
REQ-003 The block SHALL map a 16-bit linear word index w to bank w[1:0] and row w[15:2].
REQ-004 The block SHALL implement these operations (op = function_id[2:0]):
- op 0, START: base = inputs_0[15:0], count = inputs_1[15:0]
- op 1, POP: return the next streamed word
- op 2, STATUS: see REQ-017
- all other ops: respond with 0
REQ-005 The block SHALL use two states: IDLE and STREAM.
- START with count != 0: go to STREAM.
- START with count == 0: stay in or go to IDLE.
- STREAM goes to IDLE when the remaining-to-issue counter reaches 0.
REQ-006 A START SHALL flush the FIFO, and any read data returning in the following cycle SHALL be discarded.
REQ-007 In STREAM the block SHALL issue at most one read per cycle, only while (FIFO level + reads in flight) < FIFO_DEPTH.
- Issue: assert ren only on the target bank, drive its row address, then post-increment the word index modulo 2^16 and decrement remaining.
- All other portN_ren SHALL be low.
REQ-008 Read data SHALL be captured from the bank selected at issue into the FIFO tail exactly 1 cycle after issue.
REQ-009 The word index SHALL wrap from 0xFFFF to 0x0000 without error.
REQ-010 A response SHALL be registered: a command accepted at cycle N gives rsp_valid at N+1, and rsp_valid SHALL hold stable until rsp_ready.
REQ-011 cmd_ready SHALL be low while a response is pending and not yet accepted.
REQ-012 cmd_ready SHALL be low for a POP while the FIFO is empty and words remain to be issued or are in flight (POP stall); the POP is accepted in the cycle the FIFO becomes non-empty.
REQ-013 A POP SHALL return the FIFO head and pop it; a POP with the FIFO empty and nothing remaining or in flight SHALL return 0 without stalling.
REQ-014 A FIFO push and a pop in the same cycle SHALL leave the level unchanged; the FIFO SHALL never overflow.
REQ-015 rsp_payload_outputs_0 SHALL hold its last value when rsp_valid is low.

Reset
REQ-016 While reset is high, at the clock edge:
- state = IDLE; FIFO level, remaining count, word index and in-flight flag = 0
- rsp_valid = 0, rsp_payload_outputs_0 = 0, all portN_ren = 0, all portN_addr = 0
- cmd_ready = 1 from the first cycle after reset deasserts
- reset mid-stream SHALL abandon the stream and discard in-flight data

Configuration
REQ-017 Macro BANK_PREFETCHER_STATUS_EN:
- Defined: op 2 returns {remaining[15:0], 12'b0, FIFO level[3:0]}, where remaining = words not yet popped.
- Undefined: op 2 behaves as an unknown op (returns 0); no status logic is synthesized.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Banks preloaded with value = word index; START base=0x0005 count=6; six POPs -> 5,6,7,8,9,10; seventh POP -> 0 with no stall.
- START base=0xFFFE count=4 -> POPs return words 0xFFFE, 0xFFFF, 0x0000, 0x0001 (bank 2 row 0x3FFF, then bank 0 row 0).
- POP issued the same cycle as START count=3 -> cmd_ready low until the first word lands; first response = word base, rsp_valid 2 cycles after the START response.
- No POPs after START count=10 -> exactly FIFO_DEPTH=4 reads issued, then all ren low; STATUS (macro on) -> 0x000A0004.
- START count=8, pop 2 words, then START base=0x100 count=1 -> next POP returns word 0x100, not stale data; hold rsp_ready low 3 cycles -> rsp_valid and data stable.
- Reset asserted mid-stream -> next cycle: all ren low, rsp_valid=0; a following POP returns 0.
